// File: rtl/icache_mshr_alloc_ctrl_pkg.sv
// icache_mshr_alloc_ctrl_pkg: shared MSHR sizing, allocator defaults and index/count types.
package icache_mshr_alloc_ctrl_pkg;
   localparam int ENTRY_NUM    = 8;
   localparam int IDX_W        = $clog2(ENTRY_NUM);
   localparam int PF_MAX_DEF   = 2;
   localparam int DMD_KEEP_DEF = 1;
   typedef logic [IDX_W-1:0] mshr_idx_t;
   typedef logic [IDX_W:0]   mshr_cnt_t;
endpackage

// File: rtl/icache_mshr_alloc_ctrl_if.sv
// icache_mshr_alloc_ctrl_if: request, grant, release and status signals of the MSHR allocator.
interface icache_mshr_alloc_ctrl_if;
   import icache_mshr_alloc_ctrl_pkg::*;
   logic      flush;
   logic      dmd_req_vld;
   logic      dmd_req_rdy;
   logic      pf_req_vld;
   logic      pf_req_rdy;
   mshr_idx_t alloc_idx;
   logic      alloc_is_pf;
   logic      free_vld;
   mshr_idx_t free_idx;
   mshr_cnt_t free_cnt;
   logic      full;
   logic      err_dbl_free;
   modport master (
      output flush, dmd_req_vld, pf_req_vld, free_vld, free_idx,
      input  dmd_req_rdy, pf_req_rdy, alloc_idx, alloc_is_pf, free_cnt, full, err_dbl_free
   );
   modport slave (
      input  flush, dmd_req_vld, pf_req_vld, free_vld, free_idx,
      output dmd_req_rdy, pf_req_rdy, alloc_idx, alloc_is_pf, free_cnt, full, err_dbl_free
   );
endinterface

// File: rtl/icache_mshr_alloc_ctrl_lead_one.sv
// icache_mshr_alloc_ctrl_lead_one: index of the lowest set bit of a mask, plus any-set flag.
module icache_mshr_alloc_ctrl_lead_one #(
   parameter int W  = 8,
   parameter int BW = $clog2(W)
) (
   input  logic [W-1:0]  mask,
   output logic [BW-1:0] bin,
   output logic          vld
);
   assign vld = |mask;
   always_comb begin
      bin = '0;
      for (int i = W - 1; i >= 0; i--) if (mask[i]) bin = BW'(i);
   end
endmodule

// File: rtl/icache_mshr_alloc_ctrl.sv
// icache_mshr_alloc_ctrl: MSHR free list shared by demand misses (priority) and capped prefetch,
// holding one pre-reserved free entry so every grant is immediate.
module icache_mshr_alloc_ctrl
   import icache_mshr_alloc_ctrl_pkg::*;
#(
   parameter int PF_MAX   = PF_MAX_DEF,
   parameter int DMD_KEEP = DMD_KEEP_DEF
) (
   input logic                      clk,
   input logic                      rst_n,
   icache_mshr_alloc_ctrl_if.slave  bus
);
   logic [ENTRY_NUM-1:0] busy, pf_own, rsv_oh, pick_mask;
   mshr_idx_t            rsv_idx, pick_idx;
   logic                 rsv_vld, pick_vld, err;
   mshr_cnt_t            pf_cnt, free_cnt;
   logic                 dmd_gnt, pf_gnt, gnt, free_ok, free_pf;
   // the reserved entry is not busy yet, so it must be masked out of the next pick
   assign rsv_oh    = rsv_vld ? ENTRY_NUM'(1) << rsv_idx : '0;
   assign pick_mask = ~busy & ~rsv_oh;
   icache_mshr_alloc_ctrl_lead_one #(.W(ENTRY_NUM)) u_pick (
      .mask (pick_mask),
      .bin  (pick_idx),
      .vld  (pick_vld)
   );
   assign bus.dmd_req_rdy  = rsv_vld & ~bus.flush;
   assign bus.pf_req_rdy   = rsv_vld & ~bus.flush & ~bus.dmd_req_vld
                           & (pf_cnt < mshr_cnt_t'(PF_MAX)) & (free_cnt > mshr_cnt_t'(DMD_KEEP));
   assign dmd_gnt          = bus.dmd_req_vld & bus.dmd_req_rdy;
   assign pf_gnt           = bus.pf_req_vld & bus.pf_req_rdy;
   assign gnt              = dmd_gnt | pf_gnt;
   assign free_ok          = bus.free_vld & busy[bus.free_idx];
   assign free_pf          = free_ok & pf_own[bus.free_idx];
   assign bus.alloc_idx    = rsv_idx;
   assign bus.alloc_is_pf  = rsv_vld & ~bus.dmd_req_vld;
   assign bus.free_cnt     = free_cnt;
   assign bus.full         = free_cnt == '0;
   assign bus.err_dbl_free = err;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         pf_own   <= '0;
         rsv_vld  <= 1'b0;
         rsv_idx  <= '0;
         pf_cnt   <= '0;
         free_cnt <= mshr_cnt_t'(ENTRY_NUM);
         err      <= 1'b0;
      end else if (bus.flush) begin
         busy     <= '0;
         pf_own   <= '0;
         rsv_vld  <= 1'b0;
         pf_cnt   <= '0;
         free_cnt <= mshr_cnt_t'(ENTRY_NUM);
         err      <= 1'b0;
      end else begin
         if (free_ok) begin
            busy[bus.free_idx]   <= 1'b0;
            pf_own[bus.free_idx] <= 1'b0;
         end
         if (gnt) begin
            busy[rsv_idx]   <= 1'b1;
            pf_own[rsv_idx] <= pf_gnt;
         end
         if (!rsv_vld || gnt) begin
            rsv_vld <= pick_vld;
            rsv_idx <= pick_idx;
         end
         pf_cnt   <= pf_cnt + mshr_cnt_t'(pf_gnt) - mshr_cnt_t'(free_pf);
         free_cnt <= free_cnt + mshr_cnt_t'(free_ok) - mshr_cnt_t'(gnt);
         err      <= bus.free_vld & ~busy[bus.free_idx];
      end
   end
endmodule

// File: tb/tb_icache_mshr_alloc_ctrl.sv
// tb_icache_mshr_alloc_ctrl: directed and random requests against a free-list reference model;
// predicted grants go to a queue that a separate monitor checks against DUT handshakes.
module tb_icache_mshr_alloc_ctrl;
   import icache_mshr_alloc_ctrl_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   icache_mshr_alloc_ctrl_if bus ();
   icache_mshr_alloc_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int checks = 0;
   int failures = 0;
   int exp_q[$];
   bit m_busy[ENTRY_NUM];
   bit m_pf[ENTRY_NUM];
   int m_rsv;
   bit m_err;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask
   function automatic int n_free();
      int n = 0;
      for (int i = 0; i < ENTRY_NUM; i++) if (!m_busy[i]) n++;
      return n;
   endfunction
   function automatic int n_pf();
      int n = 0;
      for (int i = 0; i < ENTRY_NUM; i++) if (m_busy[i] && m_pf[i]) n++;
      return n;
   endfunction
   task automatic model_reset();
      for (int i = 0; i < ENTRY_NUM; i++) begin
         m_busy[i] = 1'b0;
         m_pf[i] = 1'b0;
      end
      m_rsv = -1;
      m_err = 1'b0;
   endtask
   // one clock cycle: drive, check registered/combinational status, predict grant, advance model
   task automatic step(input bit fl, input bit dv, input bit pv, input bit fv, input int fi);
      bit drdy, prdy;
      int g, pick;
      @(negedge clk);
      bus.flush = fl;
      bus.dmd_req_vld = dv;
      bus.pf_req_vld = pv;
      bus.free_vld = fv;
      bus.free_idx = mshr_idx_t'(fi);
      #1;
      chk("free_cnt", int'(bus.free_cnt), n_free());
      chk("full", int'(bus.full), int'(n_free() == 0));
      chk("err_dbl_free", int'(bus.err_dbl_free), int'(m_err));
      drdy = m_rsv >= 0 && !fl;
      prdy = drdy && !dv && n_pf() < PF_MAX_DEF && n_free() > DMD_KEEP_DEF;
      chk("dmd_req_rdy", int'(bus.dmd_req_rdy), int'(drdy));
      chk("pf_req_rdy", int'(bus.pf_req_rdy), int'(prdy));
      g = (dv && drdy) ? 0 : (pv && prdy) ? 1 : -1;
      if (g >= 0) exp_q.push_back(m_rsv * 2 + g);
      if (fl) model_reset();
      else begin
         pick = -1;
         for (int i = ENTRY_NUM - 1; i >= 0; i--) if (!m_busy[i] && i != m_rsv) pick = i;
         m_err = fv && !m_busy[fi];
         if (fv && m_busy[fi]) begin
            m_busy[fi] = 1'b0;
            m_pf[fi] = 1'b0;
         end
         if (g >= 0) begin
            m_busy[m_rsv] = 1'b1;
            m_pf[m_rsv] = (g == 1);
         end
         if (m_rsv < 0 || g >= 0) m_rsv = pick;
      end
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
   endtask
   task automatic do_reset();
      @(negedge clk);
      bus.flush = 0;
      bus.dmd_req_vld = 0;
      bus.pf_req_vld = 0;
      bus.free_vld = 0;
      bus.free_idx = '0;
      rst_n = 1'b0;
      #1;
      chk("rst_free_cnt", int'(bus.free_cnt), ENTRY_NUM);
      chk("rst_full", int'(bus.full), 0);
      chk("rst_dmd_rdy", int'(bus.dmd_req_rdy), 0);
      chk("rst_pf_rdy", int'(bus.pf_req_rdy), 0);
      chk("rst_alloc_idx", int'(bus.alloc_idx), 0);
      chk("rst_alloc_is_pf", int'(bus.alloc_is_pf), 0);
      chk("rst_err", int'(bus.err_dbl_free), 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask
   initial begin : monitor
      int e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && ((bus.dmd_req_vld && bus.dmd_req_rdy) || (bus.pf_req_vld && bus.pf_req_rdy))) begin
            if (exp_q.size() == 0) chk("unexpected_grant", int'(bus.alloc_idx) * 2 + int'(bus.alloc_is_pf), -1);
            else begin
               e = exp_q.pop_front();
               chk("grant_idx_pf", int'(bus.alloc_idx) * 2 + int'(bus.alloc_is_pf), e);
            end
         end
      end
   end
   initial begin : stim
      int fi;
      int s;
      bit fl, dv, pv, fv;
      bus.flush = 0;
      bus.dmd_req_vld = 0;
      bus.pf_req_vld = 0;
      bus.free_vld = 0;
      bus.free_idx = '0;
      do_reset();
      for (int k = 0; k < 11; k++) step(0, 1, 0, 0, 0);
      step(0, 1, 0, 1, 3);
      for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      idle(1);
      for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0);
      for (int k = 0; k < 2; k++) step(0, 1, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) step(0, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0);
      for (int k = 0; k < 2; k++) step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      idle(2);
      step(0, 0, 0, 1, 5);
      idle(2);
      step(0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
      for (int n = 0; n < 1500; n++) begin
         fl = ($urandom % 64) == 0;
         dv = ($urandom % 3) == 0;
         pv = ($urandom % 2) == 1;
         fv = ($urandom % 3) == 0;
         fi = $urandom % ENTRY_NUM;
         if (($urandom % 4) != 0) begin
            s = $urandom % ENTRY_NUM;
            for (int k = ENTRY_NUM - 1; k >= 0; k--) if (m_busy[(s + k) % ENTRY_NUM]) fi = (s + k) % ENTRY_NUM;
         end
         step(fl, dv, pv, fv, fi);
         if (n == 700) begin
            do_reset();
            exp_q.delete();
         end
      end
      idle(1);
      #5;
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
